// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
//
// Contents:
//   state_e        loader FSM states
//   BYTES_PER_WORD bytes per instruction word
//   LANE_ORDER     little-endian lane map; the 2-bit field at [2k+1:2k] is the word
//                  lane stored at byte offset k (shared with the memory read side)
//   lane_of()      byte offset -> word lane lookup
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam int BYTES_PER_WORD = 4;

  // Offset 0 holds lane 0 (bits 7:0), offset 3 holds lane 3 (bits 31:24).
  localparam logic [7:0] LANE_ORDER = 8'b11_10_01_00;

  function automatic logic [1:0] lane_of(input logic [1:0] offset);
    return LANE_ORDER[{offset, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/imem_byte_sel.sv
// rtl/imem_byte_sel.sv - combinational 32-to-8 byte lane select for byte-serial ports
//
// Ports:
//   word    in  32  source word
//   idx     in   2  byte offset within the word
//   byte_o  out  8  byte stored at that offset (little-endian lane order)
module imem_byte_sel
  import imem_loader_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  idx,
  output logic [7:0]  byte_o
);

  logic [1:0] lane;

  always_comb begin
    lane   = lane_of(idx);
    byte_o = word[{lane, 3'b000} +: 8];
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams 32-bit words into byte-addressed instruction memory
//
// Parameters:
//   MEM_BYTES   memory size in bytes
//   BASE_ADDR   byte address of the first word (multiple of 4)
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       begin a load session (honoured only when idle)
//   in_valid    in_data/in_last valid
//   in_data     32-bit instruction word
//   in_last     final word of the session
//   in_ready    loader accepts a word this cycle
//   we          byte write enable to instruction memory
//   waddr       byte address of the write
//   wdata       byte written
//   busy        session in progress
//   done        one-cycle pulse after the last byte of the last word
//   err         sticky overflow flag, cleared by the next start or rst
//   word_count  words fully written in the current/last session
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] word_count
);

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
  localparam logic [31:0] WORD_STEP = 32'(BYTES_PER_WORD);

  state_e      state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  logic [7:0]  lane_byte;
  logic        overflow;

  imem_byte_sel u_byte_sel (
    .word   (word_q),
    .idx    (idx_q),
    .byte_o (lane_byte)
  );

  // Widened to 33 bits so a pointer near the top of the address space cannot wrap
  // past the limit and look legal.
  assign overflow = ({1'b0, ptr_q} + {1'b0, WORD_STEP}) > MEM_LIMIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= BASE_ADDR;
      idx_q   <= 2'd0;
      cnt_q   <= 32'd0;
      word_q  <= 32'd0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    last_d  = last_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCEPT;
          ptr_d   = BASE_ADDR;
          cnt_d   = 32'd0;
          err_d   = 1'b0;
        end
      end
      ST_ACCEPT: begin
        if (in_valid) begin
          word_d  = in_data;
          last_d  = in_last;
          idx_d   = 2'd0;
          // The word is consumed either way; on overflow none of its bytes is written.
          state_d = overflow ? ST_ERROR : ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          ptr_d   = ptr_q + WORD_STEP;
          cnt_d   = cnt_q + 32'd1;
          state_d = last_q ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready   = (state_q == ST_ACCEPT);
    we         = (state_q == ST_WRITE);
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    err        = err_q;
    word_count = cnt_q;
    waddr      = 32'd0;
    wdata      = 8'd0;
    if (state_q == ST_WRITE) begin
      waddr = ptr_q + {30'd0, idx_q};
      wdata = lane_byte;
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the byte-addressed instruction memory. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes each word as four consecutive little-endian byte stores: the low byte goes to the lowest address. It sits between the host/boot interface and the instruction memory's write port and runs before the core leaves reset.

## Interface
- MEM_BYTES, 4096, memory size in bytes; the last legal byte address is MEM_BYTES-1.
- BASE_ADDR, 0, byte address of the first word written; must be a multiple of 4.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  begin a load session; sampled only in IDLE.
- in_valid  input  1  in_data/in_last are valid.
- in_data  input  32  instruction word.
- in_last  input  1  marks the final word of the session.
- in_ready  output  1  loader can accept a word this cycle.
- we  output  1  byte write enable to instruction memory.
- waddr  output  32  byte address of the write.
- wdata  output  8  byte written.
- busy  output  1  session in progress (any state except IDLE).
- done  output  1  one-cycle pulse after the last byte of an in_last word is written.
- err  output  1  sticky overflow flag; cleared by the next accepted start or by rst.
- word_count  output  32  words fully written in the current/last session.

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE, ERROR. The outputs are a Moore function of registered state.
- IDLE: in_ready=0, we=0, busy=0.
  - start=1 → ACCEPT.
  - On that transition: ptr←BASE_ADDR, word_count←0, err←0.
- ACCEPT: in_ready=1.
  - On in_valid, latch in_data and in_last into the word/last registers.
  - If ptr+4 > MEM_BYTES, go to ERROR; no byte of that word is written.
  - Otherwise go to WRITE with idx←0.
- WRITE: we=1, waddr=ptr+idx, wdata=word[8*idx+7 : 8*idx].
  - idx increments each cycle.
  - At idx=3: ptr←ptr+4, word_count←word_count+1; then go to DONE if last, else ACCEPT.
- DONE: done=1 for exactly one cycle, then IDLE. ptr and word_count hold.
- ERROR: err←1, then IDLE. err stays 1 until the next start is accepted.
- Address arithmetic is 32-bit unsigned. The overflow check uses a 33-bit compare so that ptr+4 cannot wrap.
- start while not in IDLE: ignored.
- in_valid outside ACCEPT: ignored. The word is not consumed, because in_ready=0.
- in_last with word_count reaching MEM_BYTES/4 exactly: all four bytes written, then DONE. This is not an error.
- A zero-word session is impossible; the session ends only on an in_last word or on ERROR.

## Timing
- Reset values:
  - state=IDLE, ptr=BASE_ADDR, idx=0, word_count=0.
  - in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0.
- Reset during any state aborts in the same edge; no further writes occur. Bytes already written stay in memory.
- start sampled at edge T → in_ready=1 from cycle T+1.
- Handshake at edge N (in_valid & in_ready) → writes occur in cycles N+1 … N+4, at ptr, ptr+1, ptr+2, ptr+3.
- After the word:
  - in_ready=1 again in cycle N+5 for a non-last word.
  - For a last word, done=1 in cycle N+5 and busy=0 from N+6.
- Throughput: 1 word per 5 cycles at full source rate.
- Overflow handshake at edge N → err=1 and busy=0 from cycle N+2; we stays 0 throughout.
- word_count updates on the edge ending the idx=3 write cycle.

## Structure
- Shared package holds:
  - the state enum (IDLE, ACCEPT, WRITE, DONE, ERROR);
  - BYTES_PER_WORD=4;
  - the little-endian lane-order constant, shared with the memory read side.
- Single module with one optional sub-module, imem_byte_sel: a combinational 32→8 lane select indexed by idx, reusable by any future byte-serial port.

## Test plan
- Single word: start; send in_data=0xDEADBEEF, in_last=1 → writes (0,EF),(1,BE),(2,AD),(3,DE) on 4 consecutive cycles; done pulse one cycle later; word_count=1.
- Three words with in_valid held high: 0x00000013, 0x00100093, 0x00208113, last on the third → 12 writes at addresses 0–11; in_ready spaced 5 cycles apart; word_count=3.
- Overflow with MEM_BYTES=8: send 3 words, no in_last → words 0–1 written; third word accepted with no write; err=1, busy=0; a new start clears err.
- Exact fill with MEM_BYTES=8: 2 words, in_last on the second → 8 writes, done=1, err=0.
- rst asserted in the WRITE cycle with idx=1 → no we in the following cycle; all outputs at reset values; a subsequent session restarts at BASE_ADDR.
- Stray stimulus: start pulsed mid-session and in_valid asserted in IDLE → no state change, no writes, and the word is not consumed.
